// File: rtl/div_pkg.sv
// Shared op encodings, FSM states and op-decode helpers for the serial divider.
package div_pkg;

  localparam int unsigned OP_W = 2;

  localparam logic [OP_W-1:0] OP_DIV  = 2'b00;
  localparam logic [OP_W-1:0] OP_DIVU = 2'b01;
  localparam logic [OP_W-1:0] OP_REM  = 2'b10;
  localparam logic [OP_W-1:0] OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ITER  = 2'd1,
    FIXUP = 2'd2
  } state_t;

  // funct3[0] clear means a signed variant
  function automatic logic is_signed(input logic [OP_W-1:0] op);
    return ~op[0];
  endfunction

  function automatic logic wants_rem(input logic [OP_W-1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/div_restore_step.sv
// One radix-2 restoring step: shift in a dividend bit, subtract the divisor if it fits.
module div_restore_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dvd_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next_c,
  output logic             q_bit_c
);

  logic [WIDTH:0]   partial;
  logic [WIDTH-1:0] diff;

  // The difference always fits in WIDTH bits when the subtraction is taken.
  always_comb begin
    partial    = {rem, dvd_msb};
    diff       = partial[WIDTH-1:0] - divisor;
    q_bit_c    = (partial >= {1'b0, divisor});
    rem_next_c = q_bit_c ? diff : partial[WIDTH-1:0];
  end

endmodule

// File: rtl/serial_divider.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU with a serial MSB-first quotient stream.
module serial_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             q_serial,
  output logic             q_shift_en,
  output logic             q_clear
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic             neg_q;
  logic             neg_r;
  logic             sel_rem;

  logic [WIDTH-1:0] rem_next;
  logic             q_bit;

  logic             sgn;
  logic             div_zero;
  logic             ovf;
  logic [WIDTH-1:0] dvd_abs;
  logic [WIDTH-1:0] dvs_abs;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  div_restore_step #(.WIDTH(WIDTH)) u_step (
    .rem        (rem_q),
    .dvd_msb    (dvd_q[WIDTH-1]),
    .divisor    (dvs_q),
    .rem_next_c (rem_next),
    .q_bit_c    (q_bit)
  );

  // Accept-time operand conditioning and final sign correction.
  always_comb begin
    sgn      = is_signed(op);
    div_zero = (divisor == '0);
    ovf      = sgn && (dividend == MIN_VAL) && (divisor == '1);
    dvd_abs  = (sgn && dividend[WIDTH-1]) ? WIDTH'(-dividend) : dividend;
    dvs_abs  = (sgn && divisor[WIDTH-1])  ? WIDTH'(-divisor)  : divisor;
    q_fix    = neg_q ? WIDTH'(-dvd_q) : dvd_q;
    r_fix    = neg_r ? WIDTH'(-rem_q) : rem_q;
  end

  // The dividend register doubles as the quotient accumulator as bits shift out.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      rem_q      <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      sel_rem    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      result     <= '0;
      q_serial   <= 1'b0;
      q_shift_en <= 1'b0;
      q_clear    <= 1'b0;
    end else begin
      done       <= 1'b0;
      q_clear    <= 1'b0;
      q_shift_en <= 1'b0;
      q_serial   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (div_zero) begin
              result <= wants_rem(op) ? dividend : '1;
              done   <= 1'b1;
            end else if (ovf) begin
              result <= wants_rem(op) ? '0 : MIN_VAL;
              done   <= 1'b1;
            end else begin
              state   <= ITER;
              busy    <= 1'b1;
              q_clear <= 1'b1;
              cnt     <= '0;
              rem_q   <= '0;
              dvd_q   <= dvd_abs;
              dvs_q   <= dvs_abs;
              neg_q   <= sgn && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
              neg_r   <= sgn && dividend[WIDTH-1];
              sel_rem <= wants_rem(op);
            end
          end
        end
        ITER: begin
          rem_q      <= rem_next;
          dvd_q      <= {dvd_q[WIDTH-2:0], q_bit};
          q_serial   <= q_bit;
          q_shift_en <= 1'b1;
          cnt        <= cnt + CNT_W'(1);
          if (cnt == LAST_CNT) begin
            state <= FIXUP;
          end
        end
        FIXUP: begin
          result <= sel_rem ? r_fix : q_fix;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_divider.sv
// Directed vector bench for serial_divider: result, latency, serial stream and strobes.
module tb_serial_divider;
  import div_pkg::*;

  localparam int unsigned W = 32;
  localparam int NORM_LAT = W + 1;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         q_serial;
  logic         q_shift_en;
  logic         q_clear;

  int n_checks = 0;
  int n_fail   = 0;

  serial_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .op         (op),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .q_serial   (q_serial),
    .q_shift_en (q_shift_en),
    .q_clear    (q_clear)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [W-1:0] stream;
    bit           fast;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Present one request for a single edge, then scramble the operand inputs.
  task automatic launch(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    op       = o;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    op       = 2'($urandom);
    dividend = $urandom;
    divisor  = $urandom;
  endtask

  // Observe from the cycle after accept until done; lat counts edges after accept.
  task automatic watch(input int poke_at, output int lat, output int n_clr,
                       output int n_sh, output int n_busy, output logic [W-1:0] stream);
    lat    = -1;
    n_clr  = 0;
    n_sh   = 0;
    n_busy = 0;
    stream = '0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (q_clear) n_clr++;
      if (busy) n_busy++;
      if (q_shift_en) begin
        n_sh++;
        stream = {stream[W-2:0], q_serial};
      end
      if (done) begin
        lat = c - 1;
        break;
      end
      if (c == poke_at) begin
        start    = 1'b1;
        op       = OP_DIVU;
        dividend = 32'd50;
        divisor  = 32'd5;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
    end
  endtask

  task automatic run_vec(input vec_t v, input int poke_at);
    int lat, n_clr, n_sh, n_busy;
    logic [W-1:0] stream;
    launch(v.op, v.a, v.b);
    watch(poke_at, lat, n_clr, n_sh, n_busy, stream);
    check({v.name, " result"}, result, v.res);
    check({v.name, " latency"}, lat, v.fast ? 0 : NORM_LAT);
    check({v.name, " q_clear count"}, n_clr, v.fast ? 0 : 1);
    check({v.name, " shift count"}, n_sh, v.fast ? 0 : W);
    check({v.name, " busy cycles"}, n_busy, v.fast ? 0 : NORM_LAT);
    if (!v.fast) check({v.name, " stream"}, stream, v.stream);
  endtask

  initial begin
    int lat, n_clr, n_sh, n_busy, n_done;
    logic [W-1:0] stream;

    vecs.push_back('{"divu_100_7",     OP_DIVU, 32'd100,        32'd7,          32'd14,         32'd14,         1'b0});
    vecs.push_back('{"remu_100_7",     OP_REMU, 32'd100,        32'd7,          32'd2,          32'd14,         1'b0});
    vecs.push_back('{"div_m7_2",       OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'd3,          1'b0});
    vecs.push_back('{"rem_m7_2",       OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  32'd3,          1'b0});
    vecs.push_back('{"rem_7_m2",       OP_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          32'd3,          1'b0});
    vecs.push_back('{"divu_5_0",       OP_DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd0,          1'b1});
    vecs.push_back('{"remu_5_0",       OP_REMU, 32'd5,          32'd0,          32'd5,          32'd0,          1'b1});
    vecs.push_back('{"div_5_0",        OP_DIV,  32'd5,          32'd0,          32'hFFFF_FFFF,  32'd0,          1'b1});
    vecs.push_back('{"rem_m5_0",       OP_REM,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  32'd0,          1'b1});
    vecs.push_back('{"div_min_m1",     OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b1});
    vecs.push_back('{"rem_min_m1",     OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'd0,          1'b1});
    vecs.push_back('{"divu_min_m1",    OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'd0,          1'b0});
    vecs.push_back('{"div_20_m3",      OP_DIV,  32'd20,         32'hFFFF_FFFD,  32'hFFFF_FFFA,  32'd6,          1'b0});
    vecs.push_back('{"div_m20_m3",     OP_DIV,  32'hFFFF_FFEC,  32'hFFFF_FFFD,  32'd6,          32'd6,          1'b0});
    vecs.push_back('{"rem_m20_m3",     OP_REM,  32'hFFFF_FFEC,  32'hFFFF_FFFD,  32'hFFFF_FFFE,  32'd6,          1'b0});
    vecs.push_back('{"remu_max_10",    OP_REMU, 32'hFFFF_FFFF,  32'd10,         32'd5,          32'h1999_9999,  1'b0});
    vecs.push_back('{"divu_7_9",       OP_DIVU, 32'd7,          32'd9,          32'd0,          32'd0,          1'b0});
    vecs.push_back('{"div_min_1",      OP_DIV,  32'h8000_0000,  32'd1,          32'h8000_0000,  32'h8000_0000,  1'b0});

    reset    = 1'b0;
    start    = 1'b0;
    op       = OP_DIV;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset result", result, 0);
    check("reset q_serial", q_serial, 0);
    check("reset q_shift_en", q_shift_en, 0);
    check("reset q_clear", q_clear, 0);
    reset = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) run_vec(vecs[i], 0);

    // start pulsed mid-iteration must not disturb the running op
    run_vec(vecs[0], 5);

    // Reset during iteration: everything clears and no done follows.
    launch(OP_DIVU, 32'd100, 32'd7);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("pre-reset q_shift_en", q_shift_en, 1);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("mid reset busy", busy, 0);
    check("mid reset q_shift_en", q_shift_en, 0);
    check("mid reset result", result, 0);
    check("mid reset done", done, 0);
    reset  = 1'b1;
    n_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("no done after reset", n_done, 0);
    run_vec('{"divu_9_3", OP_DIVU, 32'd9, 32'd3, 32'd3, 32'd3, 1'b0}, 0);

    // Back-to-back: start held from FIXUP through the done cycle.
    launch(OP_DIVU, 32'd100, 32'd7);
    repeat (32) @(posedge clk);
    @(negedge clk);
    op       = OP_DIVU;
    dividend = 32'd20;
    divisor  = 32'd4;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("b2b first done", done, 1);
    check("b2b first result", result, 32'd14);
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    watch(0, lat, n_clr, n_sh, n_busy, stream);
    check("b2b q_clear count", n_clr, 1);
    check("b2b latency", lat, NORM_LAT);
    check("b2b stream", stream, 32'd5);
    check("b2b result", result, 32'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
